// File: rtl/traffic_pkg.sv
// Shared types for the traffic light controller: FSM phase and per-direction lamp colour.
package traffic_pkg;

  typedef enum logic [2:0] {
    S_CLEAR,
    S_GREEN,
    S_YELLOW,
    S_PED,
    S_FLASH
  } phase_t;

  typedef enum logic [1:0] {
    LAMP_OFF,
    LAMP_RED,
    LAMP_YELLOW,
    LAMP_GREEN
  } lamp_t;

  // A duration is legal when the counter can reach dur-1 without wrapping.
  function automatic bit dur_ok(input int unsigned dur, input int unsigned cnt_w);
    return (dur != 0) && (64'(dur) <= (64'd1 << cnt_w));
  endfunction

  function automatic lamp_t lamp_of(input phase_t ph, input logic is_active,
                                    input logic flash_on);
    lamp_t l;
    l = LAMP_RED;
    unique case (ph)
      S_GREEN:  l = is_active ? LAMP_GREEN : LAMP_RED;
      S_YELLOW: l = is_active ? LAMP_YELLOW : LAMP_RED;
      S_FLASH:  l = flash_on ? LAMP_YELLOW : LAMP_OFF;
      default:  l = LAMP_RED;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Counts enabled ticks 0..dur-1; done flags the final enabled tick and the count restarts.
module phase_timer #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [CNT_W:0]   dur,
  output logic             done
);

  logic [CNT_W-1:0] cnt_q;

  assign done = en & ({1'b0, cnt_q} == (dur - (CNT_W + 1)'(1)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load || done) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/traffic_light_ctrl.sv
// Round-robin traffic light controller with all-red clearance, pedestrian phase and
// flashing-yellow mode; lamp outputs are registered from the next-state values.
module traffic_light_ctrl
  import traffic_pkg::*;
#(
  parameter int unsigned NUM_DIR   = 2,
  parameter int unsigned GREEN_CYC = 10,
  parameter int unsigned YELLOW_CYC = 3,
  parameter int unsigned CLEAR_CYC = 2,
  parameter int unsigned PED_CYC   = 8,
  parameter int unsigned FLASH_CYC = 4,
  parameter int unsigned CNT_W     = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       flash_mode,
  input  logic                       ped_req,
  output logic                       ped_ack,
  output logic                       ped_walk,
  output logic [NUM_DIR-1:0]         red,
  output logic [NUM_DIR-1:0]         yellow,
  output logic [NUM_DIR-1:0]         green,
  output logic [$clog2(NUM_DIR)-1:0] active_dir,
  output phase_t                     phase
);

  localparam int unsigned DIR_W = $clog2(NUM_DIR);

  if (NUM_DIR < 2 || NUM_DIR > 8) begin : g_bad_num_dir
    $error("traffic_light_ctrl: NUM_DIR must be in 2..8");
  end
  if (!dur_ok(GREEN_CYC, CNT_W) || !dur_ok(YELLOW_CYC, CNT_W) || !dur_ok(CLEAR_CYC, CNT_W) ||
      !dur_ok(PED_CYC, CNT_W) || !dur_ok(FLASH_CYC, CNT_W)) begin : g_bad_dur
    $error("traffic_light_ctrl: every duration must be in 1..2**CNT_W");
  end

  logic [CNT_W:0]     dur;
  logic               tmr_done;
  logic               tmr_load;
  phase_t             phase_d;
  logic [DIR_W-1:0]   dir_d;
  logic               flash_off_q, flash_off_d;
  logic               pending_q, pending_d;
  logic               ack_d;
  logic               enter_ped;
  logic [NUM_DIR-1:0] red_d, yellow_d, green_d;

  always_comb begin
    dur = (CNT_W + 1)'(CLEAR_CYC);
    unique case (phase)
      S_GREEN:  dur = (CNT_W + 1)'(GREEN_CYC);
      S_YELLOW: dur = (CNT_W + 1)'(YELLOW_CYC);
      S_PED:    dur = (CNT_W + 1)'(PED_CYC);
      S_FLASH:  dur = (CNT_W + 1)'(FLASH_CYC);
      default:  dur = (CNT_W + 1)'(CLEAR_CYC);
    endcase
  end

  phase_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk  (clk),
    .rst  (rst),
    .load (tmr_load),
    .en   (en),
    .dur  (dur),
    .done (tmr_done)
  );

  always_comb begin
    phase_d     = phase;
    dir_d       = active_dir;
    flash_off_d = flash_off_q;
    tmr_load    = 1'b0;
    if (en) begin
      unique case (phase)
        S_CLEAR: begin
          if (tmr_done) begin
            if (flash_mode) begin
              phase_d     = S_FLASH;
              flash_off_d = 1'b0;
            end else if (pending_q) begin
              phase_d = S_PED;
            end else begin
              phase_d = S_GREEN;
            end
          end
        end
        S_GREEN:  if (tmr_done) phase_d = S_YELLOW;
        S_YELLOW: begin
          if (tmr_done) begin
            phase_d = S_CLEAR;
            dir_d   = (active_dir == DIR_W'(NUM_DIR - 1)) ? '0 : active_dir + DIR_W'(1);
          end
        end
        S_PED:    if (tmr_done) phase_d = S_GREEN;
        S_FLASH: begin
          // Leaving flash restarts the timer even if it was mid half-period.
          if (!flash_mode) begin
            phase_d  = S_CLEAR;
            dir_d    = '0;
            tmr_load = 1'b1;
          end else if (tmr_done) begin
            flash_off_d = ~flash_off_q;
          end
        end
        default: phase_d = S_CLEAR;
      endcase
    end
  end

  // A request arriving as the pending one is consumed is a fresh request: set wins.
  always_comb begin
    enter_ped = en && (phase == S_CLEAR) && (phase_d == S_PED);
    pending_d = pending_q;
    ack_d     = ped_ack;
    if (en) begin
      pending_d = ped_req | (pending_q & ~enter_ped);
      ack_d     = ped_req & (~pending_q | enter_ped);
    end
  end

  always_comb begin
    lamp_t l;
    l        = LAMP_OFF;
    red_d    = '0;
    yellow_d = '0;
    green_d  = '0;
    for (int unsigned i = 0; i < NUM_DIR; i++) begin
      l           = lamp_of(phase_d, dir_d == DIR_W'(i), ~flash_off_d);
      red_d[i]    = (l == LAMP_RED);
      yellow_d[i] = (l == LAMP_YELLOW);
      green_d[i]  = (l == LAMP_GREEN);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase       <= S_CLEAR;
      active_dir  <= '0;
      flash_off_q <= 1'b0;
      pending_q   <= 1'b0;
      ped_ack     <= 1'b0;
      ped_walk    <= 1'b0;
      red         <= '1;
      yellow      <= '0;
      green       <= '0;
    end else begin
      phase       <= phase_d;
      active_dir  <= dir_d;
      flash_off_q <= flash_off_d;
      pending_q   <= pending_d;
      ped_ack     <= ack_d;
      ped_walk    <= (phase_d == S_PED);
      red         <= red_d;
      yellow      <= yellow_d;
      green       <= green_d;
    end
  end

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Bench for traffic_light_ctrl (3 directions): directed table, corner sequences and a
// randomized run against a remaining-ticks reference model.
module tb_traffic_light_ctrl;
  import traffic_pkg::*;

  localparam int N  = 3;
  localparam int GC = 10;
  localparam int YC = 3;
  localparam int CC = 2;
  localparam int PC = 8;
  localparam int FC = 4;
  localparam logic [N-1:0] ALL = '1;

  logic         clk = 1'b0;
  logic         rst, en, flash_mode, ped_req;
  logic         ped_ack, ped_walk;
  logic [N-1:0] red, yellow, green;
  logic [1:0]   active_dir;
  phase_t       phase;

  traffic_light_ctrl #(
    .NUM_DIR    (N),
    .GREEN_CYC  (GC),
    .YELLOW_CYC (YC),
    .CLEAR_CYC  (CC),
    .PED_CYC    (PC),
    .FLASH_CYC  (FC),
    .CNT_W      (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .flash_mode (flash_mode),
    .ped_req    (ped_req),
    .ped_ack    (ped_ack),
    .ped_walk   (ped_walk),
    .red        (red),
    .yellow     (yellow),
    .green      (green),
    .active_dir (active_dir),
    .phase      (phase)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: phase plus ticks left before it expires.
  phase_t m_ph;
  int     m_left, m_dir;
  logic   m_pend, m_ack, m_on;

  function automatic int dur_of(input phase_t p);
    case (p)
      S_GREEN:  return GC;
      S_YELLOW: return YC;
      S_PED:    return PC;
      S_FLASH:  return FC;
      default:  return CC;
    endcase
  endfunction

  task automatic model_reset();
    m_ph = S_CLEAR; m_left = CC; m_dir = 0; m_pend = 1'b0; m_ack = 1'b0; m_on = 1'b1;
  endtask

  task automatic model_tick(input logic e, input logic fm, input logic pr);
    logic enter_ped;
    enter_ped = 1'b0;
    if (!e) return;
    if (m_ph == S_FLASH && !fm) begin
      m_ph = S_CLEAR; m_left = CC; m_dir = 0;
    end else begin
      m_left--;
      if (m_left == 0) begin
        case (m_ph)
          S_CLEAR: begin
            if (fm) begin m_ph = S_FLASH; m_on = 1'b1; end
            else if (m_pend) begin m_ph = S_PED; enter_ped = 1'b1; end
            else m_ph = S_GREEN;
          end
          S_GREEN:  m_ph = S_YELLOW;
          S_YELLOW: begin m_ph = S_CLEAR; m_dir = (m_dir + 1) % N; end
          S_PED:    m_ph = S_GREEN;
          default:  m_on = ~m_on;
        endcase
        m_left = dur_of(m_ph);
      end
    end
    m_ack  = pr && (!m_pend || enter_ped);
    m_pend = pr || (m_pend && !enter_ped);
  endtask

  task automatic check_model(input string tag);
    logic [N-1:0] eg, ey, er;
    eg = (m_ph == S_GREEN) ? N'(1 << m_dir) : '0;
    ey = (m_ph == S_YELLOW) ? N'(1 << m_dir) : ((m_ph == S_FLASH && m_on) ? ALL : '0);
    er = (m_ph == S_FLASH) ? '0 : (ALL & ~(eg | ey));
    n_tests++;
    if ({phase, active_dir, red, yellow, green, ped_walk, ped_ack} !==
        {m_ph, 2'(m_dir), er, ey, eg, (m_ph == S_PED), m_ack}) begin
      n_fail++;
      $display("FAIL %s t=%0t: got %s dir=%0d r=%b y=%b g=%b walk=%b ack=%b, required %s dir=%0d r=%b y=%b g=%b walk=%b ack=%b",
               tag, $time, phase.name(), active_dir, red, yellow, green, ped_walk, ped_ack,
               m_ph.name(), m_dir, er, ey, eg, (m_ph == S_PED), m_ack);
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t: got 0x%0h, required 0x%0h", tag, $time, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic e, input logic fm, input logic pr);
    rst = r; en = e; flash_mode = fm; ped_req = pr;
    @(posedge clk);
    #1;
    if (r) model_reset();
    else model_tick(e, fm, pr);
    check_model("model");
  endtask

  typedef struct {
    logic         en, fm, pr;
    int           n;
    phase_t       ph;
    logic [1:0]   dir;
    logic [N-1:0] g, y, r;
    logic         walk, ack;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic e, input logic fm, input logic pr, input int n,
                              input phase_t ph, input logic [1:0] d, input logic [N-1:0] g,
                              input logic [N-1:0] y, input logic [N-1:0] r,
                              input logic w, input logic a);
    vec_t v;
    v.en = e; v.fm = fm; v.pr = pr; v.n = n; v.ph = ph; v.dir = d;
    v.g = g; v.y = y; v.r = r; v.walk = w; v.ack = a;
    return v;
  endfunction

  logic fm_r, e_r, found;
  int   cnt_y, cnt_c;

  initial begin
    // Full rotation with wrap, then a pedestrian request (with a duplicate while pending).
    tbl.push_back(mk(1, 0, 0,  1, S_CLEAR,  0, 3'b000, 3'b000, 3'b111, 0, 0));
    tbl.push_back(mk(1, 0, 0, 10, S_GREEN,  0, 3'b001, 3'b000, 3'b110, 0, 0));
    tbl.push_back(mk(1, 0, 0,  3, S_YELLOW, 0, 3'b000, 3'b001, 3'b110, 0, 0));
    tbl.push_back(mk(1, 0, 0,  2, S_CLEAR,  1, 3'b000, 3'b000, 3'b111, 0, 0));
    tbl.push_back(mk(1, 0, 0, 10, S_GREEN,  1, 3'b010, 3'b000, 3'b101, 0, 0));
    tbl.push_back(mk(1, 0, 0,  3, S_YELLOW, 1, 3'b000, 3'b010, 3'b101, 0, 0));
    tbl.push_back(mk(1, 0, 0,  2, S_CLEAR,  2, 3'b000, 3'b000, 3'b111, 0, 0));
    tbl.push_back(mk(1, 0, 0, 10, S_GREEN,  2, 3'b100, 3'b000, 3'b011, 0, 0));
    tbl.push_back(mk(1, 0, 0,  3, S_YELLOW, 2, 3'b000, 3'b100, 3'b011, 0, 0));
    tbl.push_back(mk(1, 0, 0,  2, S_CLEAR,  0, 3'b000, 3'b000, 3'b111, 0, 0));
    tbl.push_back(mk(1, 0, 0,  1, S_GREEN,  0, 3'b001, 3'b000, 3'b110, 0, 0));
    tbl.push_back(mk(1, 0, 1,  1, S_GREEN,  0, 3'b001, 3'b000, 3'b110, 0, 1));
    tbl.push_back(mk(1, 0, 0,  2, S_GREEN,  0, 3'b001, 3'b000, 3'b110, 0, 0));
    tbl.push_back(mk(1, 0, 1,  1, S_GREEN,  0, 3'b001, 3'b000, 3'b110, 0, 0));
    tbl.push_back(mk(1, 0, 0,  5, S_GREEN,  0, 3'b001, 3'b000, 3'b110, 0, 0));
    tbl.push_back(mk(1, 0, 0,  3, S_YELLOW, 0, 3'b000, 3'b001, 3'b110, 0, 0));
    tbl.push_back(mk(1, 0, 0,  2, S_CLEAR,  1, 3'b000, 3'b000, 3'b111, 0, 0));
    tbl.push_back(mk(1, 0, 0,  8, S_PED,    1, 3'b000, 3'b000, 3'b111, 1, 0));
    tbl.push_back(mk(1, 0, 0, 10, S_GREEN,  1, 3'b010, 3'b000, 3'b101, 0, 0));
    tbl.push_back(mk(1, 0, 0,  3, S_YELLOW, 1, 3'b000, 3'b010, 3'b101, 0, 0));
    tbl.push_back(mk(1, 0, 0,  2, S_CLEAR,  2, 3'b000, 3'b000, 3'b111, 0, 0));
    tbl.push_back(mk(1, 0, 0,  1, S_GREEN,  2, 3'b100, 3'b000, 3'b011, 0, 0));

    rst = 1'b0; en = 1'b1; flash_mode = 1'b0; ped_req = 1'b0;
    model_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    #1 check_model("async_reset");
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    rst = 1'b0;
    #1 check_model("release");

    foreach (tbl[i]) begin
      for (int k = 0; k < tbl[i].n; k++) begin
        step(0, tbl[i].en, tbl[i].fm, tbl[i].pr);
        n_tests++;
        if ({phase, active_dir, green, yellow, red, ped_walk, ped_ack} !==
            {tbl[i].ph, tbl[i].dir, tbl[i].g, tbl[i].y, tbl[i].r, tbl[i].walk, tbl[i].ack}) begin
          n_fail++;
          $display("FAIL table row %0d cyc %0d: got %s dir=%0d g=%b y=%b r=%b walk=%b ack=%b, required %s dir=%0d g=%b y=%b r=%b walk=%b ack=%b",
                   i, k, phase.name(), active_dir, green, yellow, red, ped_walk, ped_ack,
                   tbl[i].ph.name(), tbl[i].dir, tbl[i].g, tbl[i].y, tbl[i].r, tbl[i].walk,
                   tbl[i].ack);
        end
      end
    end

    // Flash requested at green cycle 3: green, yellow and clear all run to completion.
    step(0, 1, 0, 0);
    for (int k = 0; k < 13; k++) begin
      step(0, 1, 1, 0);
      chk("flash_no_truncate", 32'(phase),
          32'(k < 8 ? S_GREEN : (k < 11 ? S_YELLOW : S_CLEAR)));
    end
    for (int k = 0; k < 12; k++) begin
      step(0, 1, 1, 0);
      chk("flash_blink", 32'({phase, yellow, red, green}),
          32'({S_FLASH, ((k / 4) % 2 == 0) ? 3'b111 : 3'b000, 3'b000, 3'b000}));
    end
    step(0, 1, 0, 0);
    chk("flash_exit_1", 32'({phase, active_dir}), 32'({S_CLEAR, 2'd0}));
    step(0, 1, 0, 0);
    chk("flash_exit_2", 32'({phase, active_dir}), 32'({S_CLEAR, 2'd0}));
    step(0, 1, 0, 0);
    chk("flash_exit_green", 32'({phase, active_dir, green}), 32'({S_GREEN, 2'd0, 3'b001}));

    // Half-rate enable doubles every phase length.
    e_r = 1'b0; cnt_y = 0; cnt_c = 0;
    for (int k = 0; k < 200; k++) begin
      e_r = ~e_r;
      step(0, e_r, 0, 0);
      if (phase == S_YELLOW) cnt_y++;
      else if (cnt_y != 0) break;
    end
    chk("half_rate_yellow", 32'(cnt_y), 32'(2 * YC));
    if (phase == S_CLEAR) cnt_c = 1;
    for (int k = 0; k < 50 && phase == S_CLEAR; k++) begin
      e_r = ~e_r;
      step(0, e_r, 0, 0);
      if (phase == S_CLEAR) cnt_c++;
    end
    chk("half_rate_clear", 32'(cnt_c), 32'(2 * CC));

    // Reset mid-yellow with an ack in flight.
    found = 1'b0;
    for (int k = 0; k < 60 && !found; k++) begin
      step(0, 1, 0, 0);
      found = (phase == S_YELLOW);
    end
    chk("reach_yellow", 32'(found), 32'd1);
    step(0, 1, 0, 1);
    chk("ack_before_reset", 32'(ped_ack), 32'd1);
    #2 rst = 1'b1;
    #1 model_reset();
    check_model("mid_reset");
    chk("mid_reset_outputs", 32'({phase, red, yellow, green, ped_ack, ped_walk, active_dir}),
        32'({S_CLEAR, 3'b111, 3'b000, 3'b000, 1'b0, 1'b0, 2'd0}));
    step(1, 1, 0, 0);
    rst = 1'b0;
    #1 check_model("release2");
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    chk("resume_green0", 32'({phase, active_dir, green}), 32'({S_GREEN, 2'd0, 3'b001}));

    // Randomized traffic against the reference model.
    fm_r = 1'b0;
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 99) == 0) fm_r = ~fm_r;
      step($urandom_range(0, 499) == 0, $urandom_range(0, 3) != 0, fm_r,
           $urandom_range(0, 9) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
